// File: rtl/modulo_diff_encoder.sv
// Modulo-ADC encoder: folds each sample and its ORDER-th finite difference into [-2^B, 2^B).
// Optional fold statistics counter is enabled by defining FOLD_STATS_EN.
module modulo_diff_encoder #(
    parameter int OUT_RES = 24,
    parameter int B       = 10,
    parameter int ORDER   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [OUT_RES-1:0] x,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [OUT_RES-1:0] x_mod,
    output logic signed [OUT_RES-1:0] d_mod,
    output logic signed [OUT_RES-1:0] d_k,
    output logic                      warm,
    output logic [15:0]               fold_cnt
);

    localparam int W  = OUT_RES + ORDER;
    localparam int NW = (ORDER > 1) ? $clog2(ORDER) : 1;
    localparam int CW = $clog2(ORDER + 2);

    typedef enum logic [1:0] {
        IDLE,
        DIFF,
        FOLD,
        OUT
    } state_t;

    state_t                      state_q, state_d;
    logic [NW-1:0]               n_q, n_d;
    logic signed [W-1:0]         cur_q, cur_d;
    logic signed [W-1:0]         hist_q [ORDER];
    logic signed [W-1:0]         hist_d [ORDER];
    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        in_ready_q, in_ready_d;
    logic                        out_valid_q, out_valid_d;
    logic                        warm_q, warm_d;
    logic signed [OUT_RES-1:0]   x_mod_q, x_mod_d;
    logic signed [OUT_RES-1:0]   d_mod_q, d_mod_d;
    logic signed [OUT_RES-1:0]   d_k_q, d_k_d;

    logic signed [OUT_RES-1:0]   cur_fold;
    logic signed [OUT_RES-1:0]   cur_k;
    logic                        last_order;

    // Wrap of the low B+1 bits; the fold count follows from floor(cur/2^(B+1))
    // plus one when the wrapped value went negative (bit B set).
    assign cur_fold   = {{(OUT_RES-B-1){cur_q[B]}}, cur_q[B:0]};
    assign cur_k      = OUT_RES'(signed'(cur_q[W-1:B+1])) + OUT_RES'(cur_q[B]);
    assign last_order = (n_q == NW'(ORDER - 1));

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        cur_d       = cur_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        warm_d      = warm_q;
        x_mod_d     = x_mod_q;
        d_mod_d     = d_mod_q;
        d_k_d       = d_k_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cur_d   = W'(x);
                    x_mod_d = {{(OUT_RES-B-1){x[B]}}, x[B:0]};
                    n_d     = '0;
                    state_d = DIFF;
                end
            end
            DIFF: begin
                cur_d = cur_q - hist_q[n_q];
                if (last_order) begin
                    state_d = FOLD;
                end else begin
                    n_d = n_q + NW'(1);
                end
            end
            FOLD: begin
                d_mod_d     = cur_fold;
                d_k_d       = cur_k;
                cnt_d       = (cnt_q == CW'(ORDER + 1)) ? cnt_q : cnt_q + CW'(1);
                warm_d      = (cnt_d == CW'(ORDER + 1));
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    // Each history tap captures the running difference before it is reduced by that tap.
    for (genvar gi = 0; gi < ORDER; gi++) begin : g_hist
        assign hist_d[gi] = (state_q == DIFF && n_q == NW'(gi)) ? cur_q : hist_q[gi];

        always_ff @(posedge clk) begin
            if (reset) begin
                hist_q[gi] <= '0;
            end else begin
                hist_q[gi] <= hist_d[gi];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            n_q         <= '0;
            cur_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            warm_q      <= 1'b0;
            x_mod_q     <= '0;
            d_mod_q     <= '0;
            d_k_q       <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            cur_q       <= cur_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            warm_q      <= warm_d;
            x_mod_q     <= x_mod_d;
            d_mod_q     <= d_mod_d;
            d_k_q       <= d_k_d;
        end
    end

`ifdef FOLD_STATS_EN
    logic [15:0] fold_cnt_q, fold_cnt_d;

    always_comb begin
        fold_cnt_d = fold_cnt_q;
        if (state_q == FOLD && cur_k != '0 && fold_cnt_q != 16'hFFFF) begin
            fold_cnt_d = fold_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fold_cnt_q <= '0;
        end else begin
            fold_cnt_q <= fold_cnt_d;
        end
    end

    assign fold_cnt = fold_cnt_q;
`else
    assign fold_cnt = '0;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign warm      = warm_q;
    assign x_mod     = x_mod_q;
    assign d_mod     = d_mod_q;
    assign d_k       = d_k_q;

endmodule

// File: tb/tb_modulo_diff_encoder.sv
// Directed bench for modulo_diff_encoder (ORDER=2, B=10): vector table plus
// hand-written backpressure and mid-flight reset sequences.
module tb_modulo_diff_encoder;
    localparam int OUT_RES = 24;
    localparam int B       = 10;
    localparam int ORDER   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      reset;
    logic                      in_valid;
    logic                      in_ready;
    logic signed [OUT_RES-1:0] x;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [OUT_RES-1:0] x_mod;
    logic signed [OUT_RES-1:0] d_mod;
    logic signed [OUT_RES-1:0] d_k;
    logic                      warm;
    logic [15:0]               fold_cnt;

    int checks   = 0;
    int failures = 0;

    modulo_diff_encoder #(.OUT_RES(OUT_RES), .B(B), .ORDER(ORDER)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_mod     (x_mod),
        .d_mod     (d_mod),
        .d_k       (d_k),
        .warm      (warm),
        .fold_cnt  (fold_cnt)
    );

    typedef struct {
        int x;
        int xm;
        int dm;
        int dk;
        int wm;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input integer act, input integer exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Offers one sample, returns at the negedge where out_valid is first seen.
    // lat counts negedges after the accepting edge.
    task automatic send(input int v, output int lat, output bit got);
        int w;
        @(negedge clk);
        in_valid = 1'b1;
        x        = OUT_RES'(v);
        w        = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            lat      = -1;
            got      = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        got = out_valid;
        $display("sample x=%0d x_mod=%0d d_mod=%0d d_k=%0d warm=%0d fold_cnt=%0d lat=%0d",
                 v, x_mod, d_mod, d_k, warm, fold_cnt, lat);
    endtask

    task automatic chk_fold_cnt(input string name, input int exp_on);
`ifdef FOLD_STATS_EN
        chk(name, int'(fold_cnt), exp_on);
`else
        chk(name, int'(fold_cnt), 0 * exp_on);
`endif
    endtask

    initial begin
        int lat;
        bit got;
        int exp_folds;
        int pulses;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x         = '0;

        tbl[0] = '{x:  500, xm:   500, dm:  500, dk:  0, wm: 0};
        tbl[1] = '{x:  500, xm:   500, dm: -500, dk:  0, wm: 0};
        tbl[2] = '{x:  500, xm:   500, dm:    0, dk:  0, wm: 1};
        tbl[3] = '{x: 1500, xm:  -548, dm: 1000, dk:  0, wm: 1};
        tbl[4] = '{x:-3000, xm:  -952, dm:  644, dk: -3, wm: 1};
        tbl[5] = '{x: 1024, xm: -1024, dm:  332, dk:  4, wm: 1};
        tbl[6] = '{x: 1023, xm:  1023, dm:   71, dk: -2, wm: 1};
        tbl[7] = '{x: 1023, xm:  1023, dm:    1, dk:  0, wm: 1};

        do_reset();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_x_mod", int'(x_mod), 0);
        chk("rst_d_mod", int'(d_mod), 0);
        chk("rst_d_k", int'(d_k), 0);
        chk("rst_warm", warm, 0);
        chk("rst_fold_cnt", int'(fold_cnt), 0);

        exp_folds = 0;
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].x, lat, got);
            if (tbl[i].dk != 0) exp_folds++;
            chk($sformatf("vec%0d_valid", i), got, 1);
            chk($sformatf("vec%0d_latency", i), lat, 4);
            chk($sformatf("vec%0d_in_ready", i), in_ready, 0);
            chk($sformatf("vec%0d_x_mod", i), int'(x_mod), tbl[i].xm);
            chk($sformatf("vec%0d_d_mod", i), int'(d_mod), tbl[i].dm);
            chk($sformatf("vec%0d_d_k", i), int'(d_k), tbl[i].dk);
            chk($sformatf("vec%0d_warm", i), warm, tbl[i].wm);
            chk_fold_cnt($sformatf("vec%0d_fold_cnt", i), exp_folds);
        end

        // First sample against cleared history folds the difference once.
        do_reset();
        send(3000, lat, got);
        chk("d3000_valid", got, 1);
        chk("d3000_x_mod", int'(x_mod), 952);
        chk("d3000_d_mod", int'(d_mod), 952);
        chk("d3000_d_k", int'(d_k), 1);
        chk("d3000_warm", warm, 0);
        chk_fold_cnt("d3000_fold_cnt", 1);

        // Backpressure: outputs frozen, a pending sample must not be taken.
        do_reset();
        out_ready = 1'b0;
        send(700, lat, got);
        chk("bp_valid", got, 1);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            x        = OUT_RES'(123);
            @(negedge clk);
            chk($sformatf("bp%0d_out_valid", c), out_valid, 1);
            chk($sformatf("bp%0d_in_ready", c), in_ready, 0);
            chk($sformatf("bp%0d_x_mod", c), int'(x_mod), 700);
            chk($sformatf("bp%0d_d_mod", c), int'(d_mod), 700);
            chk($sformatf("bp%0d_d_k", c), int'(d_k), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_out_valid", out_valid, 0);
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_hold_d_mod", int'(d_mod), 700);
        send(700, lat, got);
        chk("bp_next_valid", got, 1);
        chk("bp_next_d_mod", int'(d_mod), -700);
        chk("bp_next_d_k", int'(d_k), 0);

        // Reset while the second difference stage is in flight.
        do_reset();
        send(500, lat, got);
        chk("rd_first_d_mod", int'(d_mod), 500);
        @(negedge clk);
        in_valid = 1'b1;
        x        = OUT_RES'(900);
        chk("rd_accept_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rd_in_ready", in_ready, 1);
        chk("rd_out_valid", out_valid, 0);
        chk("rd_d_mod", int'(d_mod), 0);
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        chk("rd_no_pulse", pulses, 0);
        send(500, lat, got);
        chk("rd_after_valid", got, 1);
        chk("rd_after_x_mod", int'(x_mod), 500);
        chk("rd_after_d_mod", int'(d_mod), 500);
        chk("rd_after_d_k", int'(d_k), 0);
        chk("rd_after_warm", warm, 0);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
